// File: rtl/sbl_pkg.sv
// Shared state encoding, serial line levels and parity helper for the serial byte loader.
package sbl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        PAR     = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } sbl_state_t;

    localparam logic SBL_IDLE_LEVEL  = 1'b1;
    localparam logic SBL_START_LEVEL = 1'b0;

    // One step of a running even-parity accumulation.
    function automatic logic sbl_par_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/serial_byte_loader_if.sv
// Serial line plus parallel load-register side of the serial byte loader.
interface serial_byte_loader_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic [WIDTH-1:0] data;
    logic             ena;
    logic             busy;
    logic             err;

    modport master (output sin, input data, input ena, input busy, input err);
    modport slave  (input sin, output data, output ena, output busy, output err);
endinterface

// File: rtl/sbl_shifter.sv
// LSB-first deserializing shift register with saturating bit counter.
// Running parity of the shifted bits is present only when SBL_PARITY_EN is defined.
module sbl_shifter
    import sbl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           shift,
    input  logic                           bit_in,
    output logic [WIDTH-1:0]               shreg,
    output logic [$clog2(WIDTH + 1)-1:0]   cnt
`ifdef SBL_PARITY_EN
    ,
    output logic                           par
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;

    // Shift register and counter; the counter parks at WIDTH instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (clear) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (shift) begin
            shreg_r <= {bit_in, shreg_r[WIDTH-1:1]};
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
        end
    end

`ifdef SBL_PARITY_EN
    logic par_r;

    // Even-parity accumulator over the data bits of the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_r <= 1'b0;
        end else if (clear) begin
            par_r <= 1'b0;
        end else if (shift) begin
            par_r <= sbl_par_step(par_r, bit_in);
        end else begin
            par_r <= par_r;
        end
    end

    assign par = par_r;
`endif

    assign shreg = shreg_r;
    assign cnt   = cnt_r;

endmodule

// File: rtl/serial_byte_loader.sv
// Start/stop framed serial deserializer producing a one-cycle load strobe for a WIDTH-bit register.
// Define SBL_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_byte_loader
    import sbl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_byte_loader_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sbl_state_t       state_r;
    sbl_state_t       state_next;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] shreg_s;
    logic [CNT_W-1:0] cnt_s;
    logic             ena_r;
    logic             err_r;
    logic             busy_r;
    logic             clear_s;
    logic             shift_s;
    logic             load_s;
    logic             err_s;
`ifdef SBL_PARITY_EN
    logic             par_s;
    logic             parerr_r;
    logic             parerr_next;
`endif

    sbl_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_s),
        .shift  (shift_s),
        .bit_in (bus.sin),
        .shreg  (shreg_s),
        .cnt    (cnt_s)
`ifdef SBL_PARITY_EN
        ,
        .par    (par_s)
`endif
    );

    // Frame sequencing: next state plus load/error decisions.
    always_comb begin
        state_next = state_r;
        clear_s    = 1'b0;
        shift_s    = 1'b0;
        load_s     = 1'b0;
        err_s      = 1'b0;
`ifdef SBL_PARITY_EN
        parerr_next = parerr_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.sin == SBL_START_LEVEL) begin
                    state_next = DATA;
                    clear_s    = 1'b1;
`ifdef SBL_PARITY_EN
                    parerr_next = 1'b0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                shift_s = 1'b1;
                if (cnt_s == LAST_BIT) begin
`ifdef SBL_PARITY_EN
                    state_next = PAR;
`else
                    state_next = STOP;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef SBL_PARITY_EN
            PAR: begin
                parerr_next = sbl_par_step(par_s, bus.sin);
                state_next  = STOP;
            end
`endif
            STOP: begin
                if (bus.sin == SBL_IDLE_LEVEL) begin
`ifdef SBL_PARITY_EN
                    if (parerr_r) begin
                        err_s = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
`else
                    load_s = 1'b1;
`endif
                    state_next = IDLE;
                end else begin
                    // A low stop bit may be a stuck line; wait for idle before rearming.
                    err_s      = 1'b1;
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                if (bus.sin == SBL_IDLE_LEVEL) begin
                    state_next = IDLE;
                end else begin
                    state_next = RECOVER;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; data only moves on a good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            data_r  <= {WIDTH{1'b0}};
            ena_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
`ifdef SBL_PARITY_EN
            parerr_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next;
            if (load_s) begin
                data_r <= shreg_s;
            end else begin
                data_r <= data_r;
            end
            ena_r  <= load_s;
            err_r  <= err_s;
            busy_r <= (state_next != IDLE);
`ifdef SBL_PARITY_EN
            parerr_r <= parerr_next;
`endif
        end
    end

    assign bus.data = data_r;
    assign bus.ena  = ena_r;
    assign bus.err  = err_r;
    assign bus.busy = busy_r;

endmodule
